// File: rtl/mem_read_arbiter.sv
// Read-port arbiter: I-cache, D-cache and prefetcher share one AXI read channel.
// Optional prefetch throttle: define MEM_ARB_PF_THROTTLE_EN.
module mem_read_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int LEN_W      = 4,
  parameter int PF_HOLDOFF = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        s_arvalid,
  input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
  input  logic [NUM_REQ*LEN_W-1:0]  s_arlen,
  input  logic [NUM_REQ*ID_W-1:0]   s_arid,
  output logic [NUM_REQ-1:0]        s_arready,
  output logic [NUM_REQ-1:0]        s_rvalid,
  output logic [DATA_W-1:0]         s_rdata,
  output logic                      s_rlast,
  input  logic [NUM_REQ-1:0]        s_rready,
  output logic                      m_arvalid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [LEN_W-1:0]          m_arlen,
  output logic [ID_W-1:0]           m_arid,
  input  logic                      m_arready,
  input  logic                      m_rvalid,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [ID_W-1:0]           m_rid,
  output logic                      m_rready,
  output logic                      busy,
  output logic                      err_rid
);

  // state | meaning
  // IDLE  | arbitrate; pulse s_arready to the winner and latch its request
  // ADDR  | present latched request on the memory address channel
  // DATA  | route read beats to the granted requester until the last beat

  localparam int ND = NUM_REQ - 1;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [GW-1:0] PF_IDX = GW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || PF_HOLDOFF < 1) begin : g_bad_params
    $error("mem_read_arbiter: NUM_REQ must be >= 2 and PF_HOLDOFF >= 1");
  end

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       win_idx, cand;
  logic                win;
  logic                any_demand;
  logic                pf_ok;
  logic                beat_acc;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [ID_W-1:0]     id_q;
  logic [LEN_W:0]      beat_q;
  logic                err_q;

  assign any_demand = |s_arvalid[ND-1:0];

`ifdef MEM_ARB_PF_THROTTLE_EN
  localparam int IW = $clog2(PF_HOLDOFF + 1);
  logic [IW-1:0] idle_q, idle_d;

  // idle_d already counts the current cycle, so eligibility uses it directly
  always_comb begin
    if (any_demand)                      idle_d = '0;
    else if (idle_q == IW'(PF_HOLDOFF))  idle_d = idle_q;
    else                                 idle_d = idle_q + IW'(1);
  end

  assign pf_ok = (idle_d == IW'(PF_HOLDOFF));

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  assign pf_ok = 1'b1;
`endif

  // Demand requesters searched cyclically from rr; prefetcher only as fallback
  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < ND; k++) begin
      cand = GW'((int'(rr_q) + k) % ND);
      if (!win && s_arvalid[cand]) begin
        win     = 1'b1;
        win_idx = cand;
      end
    end
    if (!win && s_arvalid[PF_IDX] && pf_ok) begin
      win     = 1'b1;
      win_idx = PF_IDX;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    s_arready = '0;
    s_rvalid  = '0;
    s_rdata   = '0;
    s_rlast   = 1'b0;
    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arid    = '0;
    m_rready  = 1'b0;
    beat_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win && !rst) begin
          s_arready[win_idx] = 1'b1;
          grant_d            = win_idx;
          state_d            = ADDR;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        m_araddr  = addr_q;
        m_arlen   = len_q;
        m_arid    = id_q;
        if (m_arready) state_d = DATA;
      end
      DATA: begin
        m_rready          = s_rready[grant_q];
        s_rvalid[grant_q] = m_rvalid;
        s_rdata           = m_rdata;
        s_rlast           = (beat_q == {1'b0, len_q});
        beat_acc          = m_rvalid && s_rready[grant_q];
        if (beat_acc && s_rlast) begin
          state_d = IDLE;
          if (grant_q != PF_IDX)
            rr_d = (grant_q == GW'(ND - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      if (state_q == IDLE && win) begin
        addr_q <= s_araddr[win_idx*ADDR_W +: ADDR_W];
        len_q  <= s_arlen[win_idx*LEN_W +: LEN_W];
        id_q   <= s_arid[win_idx*ID_W +: ID_W];
      end
      if (state_q == ADDR && m_arready) beat_q <= '0;
      else if (beat_acc)                beat_q <= beat_q + 1'b1;
      if (beat_acc && m_rid != id_q)    err_q  <= 1'b1;
    end
  end

  assign busy    = (state_q != IDLE);
  assign err_rid = err_q;

endmodule
